// File: rtl/gcnt_n.sv
// Parametrised up/down Gray-code counter with load, wrap/saturate mode and status pulses.
// The Gray bus is registered from the next binary value, so it cannot glitch.
module gcnt_n #(
    parameter int                WIDTH    = 4,
    parameter int                SATURATE = 0,
    parameter logic [WIDTH-1:0]  INIT     = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_trig,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count_bin,
    output logic [WIDTH-1:0] o_count_gray,
    output logic             o_wrap,
    output logic             o_sat
);

    localparam logic [WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [WIDTH-1:0] INIT_GRAY = INIT ^ (INIT >> 1);
    localparam bit               SAT_MODE  = (SATURATE != 0);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;
    logic             r_sat;

    logic [WIDTH-1:0] w_next_bin;
    logic [WIDTH-1:0] w_next_gray;
    logic             w_next_wrap;
    logic             w_next_sat;
    logic             w_at_top;
    logic             w_at_bot;

    assign w_at_top = (r_bin == ALL_ONES);
    assign w_at_bot = (r_bin == '0);

    always_comb begin
        w_next_bin  = r_bin;
        w_next_wrap = 1'b0;
        w_next_sat  = 1'b0;
        if (i_load) begin
            w_next_bin = i_load_val;
        end else if (i_en) begin
            if (!i_trig) begin
                if (!w_at_top) begin
                    w_next_bin = r_bin + 1'b1;
                end else if (!SAT_MODE) begin
                    w_next_bin  = '0;
                    w_next_wrap = 1'b1;
                end else begin
                    w_next_sat = 1'b1;
                end
            end else begin
                if (!w_at_bot) begin
                    w_next_bin = r_bin - 1'b1;
                end else if (!SAT_MODE) begin
                    w_next_bin  = ALL_ONES;
                    w_next_wrap = 1'b1;
                end else begin
                    w_next_sat = 1'b1;
                end
            end
        end
    end

    // Gray derived from the next-state value, never from the binary flop outputs.
    assign w_next_gray = w_next_bin ^ (w_next_bin >> 1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bin  <= INIT;
            r_gray <= INIT_GRAY;
            r_wrap <= 1'b0;
            r_sat  <= 1'b0;
        end else begin
            r_bin  <= w_next_bin;
            r_gray <= w_next_gray;
            r_wrap <= w_next_wrap;
            r_sat  <= w_next_sat;
        end
    end

    assign o_count_bin  = r_bin;
    assign o_count_gray = r_gray;
    assign o_wrap       = r_wrap;
    assign o_sat        = r_sat;

endmodule

// File: tb/tb_gcnt_n.sv
// Scoreboard bench for gcnt_n: one wrapping and one saturating instance driven by shared
// directed vectors; expectations are queued at drive time and checked by a separate monitor.
module tb_gcnt_n;

    logic       clk = 1'b0;
    logic       rst, load, en, trig;
    logic [3:0] lv;
    logic [3:0] b0, g0, b1, g1;
    logic       w0, s0, w1, s1;

    always #5 clk = ~clk;

    gcnt_n #(.WIDTH(4), .SATURATE(0), .INIT(4'h0)) u_wrap (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_trig(trig), .i_load(load),
        .i_load_val(lv), .o_count_bin(b0), .o_count_gray(g0), .o_wrap(w0), .o_sat(s0)
    );

    gcnt_n #(.WIDTH(4), .SATURATE(1), .INIT(4'h3)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_trig(trig), .i_load(load),
        .i_load_val(lv), .o_count_bin(b1), .o_count_gray(g1), .o_wrap(w1), .o_sat(s1)
    );

    typedef struct packed {
        logic [3:0] bin;
        logic [3:0] gray;
        logic       w;
        logic       s;
        logic       one;
    } exp_t;

    typedef struct packed {
        logic c0;
        exp_t e0;
        logic c1;
        exp_t e1;
    } sb_t;

    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [3:0] gtab [16];
    exp_t nc;

    function automatic exp_t X(input logic [3:0] b, input logic [3:0] g,
                               input logic w, input logic s, input logic o);
        exp_t r;
        r.bin = b; r.gray = g; r.w = w; r.s = s; r.one = o;
        return r;
    endfunction

    task automatic cmp(input string nm, input int d, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d: got %h, expected %h at %0t", nm, d, act, req, $time);
        end
    endtask

    task automatic chk_dut(input int d, input exp_t x, input logic [3:0] ab, input logic [3:0] ag,
                           input logic aw, input logic as, input logic [3:0] pg);
        cmp("count_bin", d, ab, x.bin);
        cmp("count_gray", d, ag, x.gray);
        cmp("wrap", d, {3'b0, aw}, {3'b0, x.w});
        cmp("sat", d, {3'b0, as}, {3'b0, x.s});
        if (x.one) begin
            checks++;
            if ($countones(ag ^ pg) != 1) begin
                errors++;
                $display("FAIL gray_hamming dut%0d: gray %h after %h, expected one bit change", d, ag, pg);
            end
        end
    endtask

    task automatic step(input logic r, input logic l, input logic [3:0] v, input logic e,
                        input logic t, input logic c0, input exp_t x0, input logic c1, input exp_t x1);
        sb_t item;
        @(negedge clk);
        rst = r; load = l; lv = v; en = e; trig = t;
        item.c0 = c0; item.e0 = x0; item.c1 = c1; item.e1 = x1;
        sb.push_back(item);
    endtask

    // Monitor: one queued expectation is consumed per rising edge.
    initial begin
        logic [3:0] pg0;
        logic [3:0] pg1;
        sb_t e;
        pg0 = '0;
        pg1 = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.c0) chk_dut(0, e.e0, b0, g0, w0, s0, pg0);
                if (e.c1) chk_dut(1, e.e1, b1, g1, w1, s1, pg1);
            end
            pg0 = g0;
            pg1 = g1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        nc = '0;
        rst = 1'b1; load = 1'b0; lv = 4'h0; en = 1'b0; trig = 1'b0;

        // reset held two edges, then hold
        step(1, 0, 4'h0, 0, 0, 1, X(4'h0, 4'h0, 0, 0, 0), 1, X(4'h3, 4'h2, 0, 0, 0));
        step(1, 0, 4'h0, 0, 0, 1, X(4'h0, 4'h0, 0, 0, 0), 1, X(4'h3, 4'h2, 0, 0, 0));
        step(0, 0, 4'h0, 0, 0, 1, X(4'h0, 4'h0, 0, 0, 0), 1, X(4'h3, 4'h2, 0, 0, 0));
        step(0, 0, 4'h0, 0, 0, 1, X(4'h0, 4'h0, 0, 0, 0), 1, X(4'h3, 4'h2, 0, 0, 0));

        // up sweep through the wrap
        for (int i = 1; i <= 17; i++)
            step(0, 0, 4'h0, 1, 0, 1, X(4'(i % 16), gtab[i % 16], (i == 16), 0, 1), 0, nc);

        // down to zero, then wrap to all-ones
        step(0, 0, 4'h0, 1, 1, 1, X(4'h0, 4'h0, 0, 0, 1), 0, nc);
        step(0, 0, 4'h0, 1, 1, 1, X(4'hF, 4'h8, 1, 0, 1), 0, nc);
        step(0, 0, 4'h0, 0, 1, 1, X(4'hF, 4'h8, 0, 0, 0), 0, nc);

        // saturate vs wrap on the same vectors
        step(0, 1, 4'hE, 0, 0, 1, X(4'hE, 4'h9, 0, 0, 0), 1, X(4'hE, 4'h9, 0, 0, 0));
        step(0, 0, 4'h0, 1, 0, 1, X(4'hF, 4'h8, 0, 0, 1), 1, X(4'hF, 4'h8, 0, 0, 1));
        step(0, 0, 4'h0, 1, 0, 1, X(4'h0, 4'h0, 1, 0, 1), 1, X(4'hF, 4'h8, 0, 1, 0));
        step(0, 0, 4'h0, 1, 0, 1, X(4'h1, 4'h1, 0, 0, 1), 1, X(4'hF, 4'h8, 0, 1, 0));
        step(0, 0, 4'h0, 1, 1, 1, X(4'h0, 4'h0, 0, 0, 1), 1, X(4'hE, 4'h9, 0, 0, 1));
        step(0, 1, 4'h0, 0, 1, 1, X(4'h0, 4'h0, 0, 0, 0), 1, X(4'h0, 4'h0, 0, 0, 0));
        step(0, 0, 4'h0, 1, 1, 1, X(4'hF, 4'h8, 1, 0, 1), 1, X(4'h0, 4'h0, 0, 1, 0));
        step(0, 0, 4'h0, 0, 1, 1, X(4'hF, 4'h8, 0, 0, 0), 1, X(4'h0, 4'h0, 0, 0, 0));

        // priority: load over en, rst over load
        step(0, 1, 4'h9, 1, 0, 1, X(4'h9, 4'hD, 0, 0, 0), 1, X(4'h9, 4'hD, 0, 0, 0));
        step(1, 1, 4'h9, 1, 0, 1, X(4'h0, 4'h0, 0, 0, 0), 1, X(4'h3, 4'h2, 0, 0, 0));

        // count to 5, reset mid-count, then alternate direction
        step(0, 0, 4'h0, 1, 0, 1, X(4'h1, 4'h1, 0, 0, 1), 0, nc);
        step(0, 0, 4'h0, 1, 0, 1, X(4'h2, 4'h3, 0, 0, 1), 0, nc);
        step(0, 0, 4'h0, 1, 0, 1, X(4'h3, 4'h2, 0, 0, 1), 0, nc);
        step(0, 0, 4'h0, 1, 0, 1, X(4'h4, 4'h6, 0, 0, 1), 0, nc);
        step(0, 0, 4'h0, 1, 0, 1, X(4'h5, 4'h7, 0, 0, 1), 0, nc);
        step(1, 0, 4'h0, 1, 0, 1, X(4'h0, 4'h0, 0, 0, 0), 1, X(4'h3, 4'h2, 0, 0, 0));
        step(0, 0, 4'h0, 1, 0, 1, X(4'h1, 4'h1, 0, 0, 1), 1, X(4'h4, 4'h6, 0, 0, 1));
        step(0, 0, 4'h0, 1, 1, 1, X(4'h0, 4'h0, 0, 0, 1), 1, X(4'h3, 4'h2, 0, 0, 1));
        step(0, 0, 4'h0, 1, 0, 1, X(4'h1, 4'h1, 0, 0, 1), 1, X(4'h4, 4'h6, 0, 0, 1));
        step(0, 0, 4'h0, 1, 1, 1, X(4'h0, 4'h0, 0, 0, 1), 1, X(4'h3, 4'h2, 0, 0, 1));
        step(0, 0, 4'h0, 0, 0, 1, X(4'h0, 4'h0, 0, 0, 0), 1, X(4'h3, 4'h2, 0, 0, 0));

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
